// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter: FSM encodings, counter width and default sizes.
package sdram_arb_pkg;

  localparam int unsigned TIMEOUT_W     = 8;
  localparam int unsigned DEF_NUM_PORTS = 3;
  localparam int unsigned DEF_ADRS_W    = 25;
  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_BE_W      = 4;
  localparam int unsigned DEF_TIMEOUT   = 255;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Width of a port index; at least one bit even for degenerate counts.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_port_arb_rr_pick.sv
// Combinational round-robin picker: first requester found scanning upward from last_grant+1.
module rr_pick
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = DEF_NUM_PORTS,
  parameter int unsigned PW        = idx_w(DEF_NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [PW-1:0]        i_last_grant,
  output logic [PW-1:0]        o_grant,
  output logic                 o_any_req
);

  logic [2*NUM_PORTS-1:0] w_dbl;
  logic [NUM_PORTS-1:0]   w_rot;
  logic                   w_found;
  int unsigned            w_g;

  // Doubling the vector turns the wrap-around scan into a plain shift plus priority encode.
  always_comb begin
    w_dbl   = {i_req, i_req} >> (32'(i_last_grant) + 32'd1);
    w_rot   = w_dbl[NUM_PORTS-1:0];
    w_found = 1'b0;
    w_g     = 0;
    for (int unsigned j = 0; j < NUM_PORTS; j++) begin
      if (!w_found && w_rot[j]) begin
        w_found = 1'b1;
        w_g     = 32'(i_last_grant) + 32'd1 + j;
      end
    end
    if (w_g >= NUM_PORTS) w_g = w_g - NUM_PORTS;
    o_grant = PW'(w_g);
  end

  assign o_any_req = |i_req;

endmodule

// File: rtl/sdram_port_arb.sv
// Round-robin arbiter merging several requesters onto the single sdram_ctrl_100 command port.
module sdram_port_arb
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = DEF_NUM_PORTS,
  parameter int unsigned ADRS_W    = DEF_ADRS_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned BE_W      = DEF_BE_W,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                        m_clock,
  input  logic                        p_reset,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS-1:0]        req_read,
  input  logic [NUM_PORTS*ADRS_W-1:0] req_adrs,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  input  logic [NUM_PORTS*BE_W-1:0]   req_de,
  output logic [NUM_PORTS-1:0]        port_ack,
  output logic [DATA_W-1:0]           port_rdata,
  output logic [NUM_PORTS-1:0]        port_err,
  output logic                        sdram_write,
  output logic                        sdram_read,
  output logic [ADRS_W-1:0]           sdram_adrs,
  output logic [DATA_W-1:0]           sdram_wdata,
  output logic [BE_W-1:0]             sdram_de,
  input  logic [DATA_W-1:0]           sdram_rdata,
  input  logic                        sdram_ack,
  input  logic                        sdram_refresh_doing,
  input  logic                        sdram_err,
  output logic                        err_sticky
);

  localparam int unsigned PW = idx_w(NUM_PORTS);

  logic [1:0]           r_state;
  logic [PW-1:0]        r_grant;
  logic [PW-1:0]        r_last_grant;
  logic [TIMEOUT_W-1:0] r_cnt;
  logic                 r_sdram_write;
  logic                 r_sdram_read;
  logic [ADRS_W-1:0]    r_adrs;
  logic [DATA_W-1:0]    r_wdata;
  logic [BE_W-1:0]      r_de;
  logic [NUM_PORTS-1:0] r_port_ack;
  logic [NUM_PORTS-1:0] r_port_err;
  logic [DATA_W-1:0]    r_port_rdata;
  logic                 r_err_sticky;

  logic [NUM_PORTS-1:0] w_req;
  logic [PW-1:0]        w_pick;
  logic                 w_any;
  logic                 w_sel_wr;
  logic [ADRS_W-1:0]    w_sel_adrs;
  logic [DATA_W-1:0]    w_sel_wdata;
  logic [BE_W-1:0]      w_sel_de;

  assign w_req = req_write | req_read;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PW        (PW)
  ) u_pick (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_pick),
    .o_any_req    (w_any)
  );

  always_comb begin
    w_sel_wr    = 1'b0;
    w_sel_adrs  = '0;
    w_sel_wdata = '0;
    w_sel_de    = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (PW'(p) == w_pick) begin
        w_sel_wr    = req_write[p];
        w_sel_adrs  = req_adrs[p*ADRS_W +: ADRS_W];
        w_sel_wdata = req_wdata[p*DATA_W +: DATA_W];
        w_sel_de    = req_de[p*BE_W +: BE_W];
      end
    end
  end

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_last_grant  <= PW'(NUM_PORTS - 1);
      r_cnt         <= '0;
      r_sdram_write <= 1'b0;
      r_sdram_read  <= 1'b0;
      r_adrs        <= '0;
      r_wdata       <= '0;
      r_de          <= '0;
      r_port_ack    <= '0;
      r_port_err    <= '0;
      r_port_rdata  <= '0;
      r_err_sticky  <= 1'b0;
    end else begin
      r_sdram_write <= 1'b0;
      r_sdram_read  <= 1'b0;
      r_port_ack    <= '0;
      r_port_err    <= '0;
      if (sdram_err) r_err_sticky <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          // Strobes are registered here so they coincide with the ISSUE cycle.
          if (w_any && !sdram_refresh_doing) begin
            r_grant       <= w_pick;
            r_adrs        <= w_sel_adrs;
            r_wdata       <= w_sel_wdata;
            r_de          <= w_sel_de;
            r_sdram_write <= w_sel_wr;
            r_sdram_read  <= !w_sel_wr;
            r_state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (sdram_ack) begin
            r_port_rdata        <= sdram_rdata;
            r_port_ack[r_grant] <= 1'b1;
            r_last_grant        <= r_grant;
            r_state             <= ST_DONE;
          end else if (r_cnt == TIMEOUT_W'(TIMEOUT - 1)) begin
            r_port_rdata        <= '0;
            r_port_ack[r_grant] <= 1'b1;
            r_port_err[r_grant] <= 1'b1;
            r_err_sticky        <= 1'b1;
            r_state             <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + TIMEOUT_W'(1);
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sdram_write = r_sdram_write;
  assign sdram_read  = r_sdram_read;
  assign sdram_adrs  = r_adrs;
  assign sdram_wdata = r_wdata;
  assign sdram_de    = r_de;
  assign port_ack    = r_port_ack;
  assign port_err    = r_port_err;
  assign port_rdata  = r_port_rdata;
  assign err_sticky  = r_err_sticky;

endmodule
